// File: rtl/dff_8.sv
// Enabled data register with asynchronous active-high reset.
// Storage element for pipeline stages, operand latches and systolic cells.
module dff_8 #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Reset dominates any coincident enabled load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= RESET_VALUE;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_dff_8.sv
// Directed, table-driven bench for dff_8 (default and 16-bit instances).
module tb_dff_8;

  logic        clk;
  logic        reset;
  logic        en;
  logic [7:0]  d;
  logic [7:0]  q;

  logic        reset16;
  logic        en16;
  logic [15:0] d16;
  logic [15:0] q16;

  int unsigned n_pass;
  int unsigned n_total;
  logic        saw_aa;
  logic        watch_aa;

  dff_8 u_dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (d),
    .q     (q)
  );

  dff_8 #(
    .WIDTH       (16),
    .RESET_VALUE (16'h1234)
  ) u_dut16 (
    .clk   (clk),
    .reset (reset16),
    .en    (en16),
    .d     (d16),
    .q     (q16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(q) if (watch_aa && q === 8'hAA) saw_aa = 1'b1;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_pass   = 0;
    n_total  = 0;
    saw_aa   = 1'b0;
    watch_aa = 1'b0;
    reset    = 1'b1;
    en       = 1'b1;
    d        = 8'hA5;
    reset16  = 1'b1;
    en16     = 1'b1;
    d16      = 16'hBEEF;

    // {reset, en, d, expected q after the edge}
    vecs[0]  = '{1'b1, 1'b1, 8'hA5, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 8'hA5, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'h0F, 8'h0F};
    vecs[3]  = '{1'b0, 1'b1, 8'hF0, 8'hF0};
    vecs[4]  = '{1'b0, 1'b0, 8'h0F, 8'hF0};
    vecs[5]  = '{1'b0, 1'b0, 8'h0F, 8'hF0};
    vecs[6]  = '{1'b0, 1'b1, 8'h0F, 8'h0F};
    vecs[7]  = '{1'b0, 1'b1, 8'hF0, 8'hF0};
    vecs[8]  = '{1'b1, 1'b1, 8'hFF, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 8'h3C, 8'h3C};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 8'hFF, 8'hFF};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 8'hFF};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      en    = vecs[i].en;
      d     = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {8'h00, q}, {8'h00, vecs[i].exp_q});
    end

    // Asynchronous reset pulse between edges, held through two edges.
    @(negedge clk);
    en = 1'b1;
    d  = 8'hA5;
    #2 reset = 1'b1;
    #1 check("async_reset_immediate", {8'h00, q}, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check($sformatf("reset_held_edge%0d", i), {8'h00, q}, 16'h0000);
    end

    // Release, load a known baseline.
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    d     = 8'h00;
    @(posedge clk);
    #1 check("baseline_load", {8'h00, q}, 16'h0000);

    // Intra-cycle glitch on d: only the value present at the edge is captured.
    @(negedge clk);
    watch_aa = 1'b1;
    d = 8'h55;
    #1 d = 8'hAA;
    #1 check("no_load_between_edges", {8'h00, q}, 16'h0000);
    #1 d = 8'h55;
    @(posedge clk);
    #1 check("glitch_edge_value", {8'h00, q}, 16'h0055);
    @(negedge clk);
    watch_aa = 1'b0;
    check("glitch_never_aa", {15'h0, saw_aa}, 16'h0000);

    // Hold with d wiggling between edges.
    en = 1'b0;
    d  = 8'h12;
    #2 d = 8'h34;
    @(posedge clk);
    #1 check("hold_wiggle", {8'h00, q}, 16'h0055);

    // 16-bit instance with non-zero reset value.
    check("p16_reset", q16, 16'h1234);
    @(negedge clk);
    reset16 = 1'b0;
    en16    = 1'b1;
    d16     = 16'hBEEF;
    @(posedge clk);
    #1 check("p16_load", q16, 16'hBEEF);
    @(negedge clk);
    en16 = 1'b0;
    d16  = 16'h0000;
    @(posedge clk);
    #1 check("p16_hold", q16, 16'hBEEF);
    @(negedge clk);
    #1 reset16 = 1'b1;
    #1 check("p16_async_reset", q16, 16'h1234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
